lab4_branch_branch_global_dpath: RTL

- Datapath half of the global-history branch predictor. Sits on the other end of the control/status interface of the global predictor control FSM.
- Holds the global history register (GHR) and the pattern history table (PHT) of 2-bit saturating counters. Provides the combinational prediction for the fetch PC.
- Consumes the control unit's increment_entry, decrement_entry and update_ghr strobes. Returns entry_upper_reached and entry_lower_reached to the control unit.

---
 rtl/lab4_branch_branch_global_dpath_pkg.sv | 14 +
 rtl/lab4_branch_branch_global_dpath_ghr.sv | 20 ++
 rtl/lab4_branch_branch_global_dpath.sv | 76 +++++++
 3 files changed

// File: rtl/lab4_branch_branch_global_dpath_pkg.sv
// rtl/lab4_branch_branch_global_dpath_pkg.sv - shared counter type and constants for the global branch predictor
package lab4_branch_BranchPkg;

  typedef logic [1:0] sat_ctr_t;

  localparam sat_ctr_t CTR_SNT   = 2'b00;
  localparam sat_ctr_t CTR_WNT   = 2'b01;
  localparam sat_ctr_t CTR_WT    = 2'b10;
  localparam sat_ctr_t CTR_ST    = 2'b11;
  localparam sat_ctr_t CTR_RESET = CTR_WNT;

  localparam int PHT_SIZE_DEFAULT = 2048;

endpackage

// File: rtl/lab4_branch_branch_global_dpath_ghr.sv
// rtl/lab4_branch_branch_global_dpath_ghr.sv - global history shift register, newest outcome in the LSB
module lab4_branch_BranchGhr #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] ghr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (shift_en) begin
      ghr <= {ghr[W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/lab4_branch_branch_global_dpath.sv
// rtl/lab4_branch_branch_global_dpath.sv - GHR + PHT datapath of the global predictor; LAB4_BRANCH_GSHARE_EN selects gshare hashing
module lab4_branch_branch_global_dpath
  import lab4_branch_BranchPkg::*;
#(
  parameter int PHT_size = PHT_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic        prediction,
  input  logic        update_en,
  input  logic        update_val,
  input  logic        increment_entry,
  input  logic        decrement_entry,
  input  logic        update_ghr,
  output logic        entry_upper_reached,
  output logic        entry_lower_reached
);

  localparam int idx_nbits = $clog2(PHT_size);

  logic [idx_nbits-1:0] ghr;
  logic [idx_nbits-1:0] lk_idx;
  logic [idx_nbits-1:0] upd_idx_reg;
  logic                 upd_val_reg;
  sat_ctr_t             pht [PHT_size];
  sat_ctr_t             upd_entry;

`ifdef LAB4_BRANCH_GSHARE_EN
  logic unused_pc;
  assign lk_idx    = PC[idx_nbits+1:2] ^ ghr;
  assign unused_pc = ^{PC[31:idx_nbits+2], PC[1:0]};
`else
  // Pure global history: the PC does not participate in indexing.
  logic unused_pc;
  assign lk_idx    = ghr;
  assign unused_pc = ^PC;
`endif

  lab4_branch_BranchGhr #(.W(idx_nbits)) u_ghr (
    .clk      (clk),
    .reset    (reset),
    .shift_en (update_ghr),
    .shift_in (upd_val_reg),
    .ghr      (ghr)
  );

  assign prediction          = pht[lk_idx][1];
  assign upd_entry           = pht[upd_idx_reg];
  assign entry_upper_reached = (upd_entry == CTR_ST);
  assign entry_lower_reached = (upd_entry == CTR_SNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_idx_reg <= '0;
      upd_val_reg <= 1'b0;
    end else if (update_en) begin
      upd_idx_reg <= lk_idx;
      upd_val_reg <= update_val;
    end
  end

  // Both strobes at once is illegal from the controller; treat it as hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_size; i++) begin
        pht[i] <= CTR_RESET;
      end
    end else if (increment_entry && !decrement_entry) begin
      if (upd_entry != CTR_ST) pht[upd_idx_reg] <= upd_entry + 2'd1;
    end else if (decrement_entry && !increment_entry) begin
      if (upd_entry != CTR_SNT) pht[upd_idx_reg] <= upd_entry - 2'd1;
    end
  end

endmodule
